spi_register_target: RTL and testbench



---
 rtl/spi_register_target.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_register_target.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_target.sv
// spi_register_target
//   SPI mode-0 target modelling an accelerometer-style register map.
//   spi_cs/spi_clk/spi_mosi are oversampled on clk and 16-bit frames
//   {R/W, addr[6:0], data[7:0]} are decoded; read data is returned on spi_miso.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   spi_cs           chip select, active low
//   spi_clk          SPI serial clock, idle low
//   spi_mosi         serial data in, MSB first
//   spi_miso         serial data out, MSB first
//   spi_miso_oe      MISO output enable (synchronized cs low, not after reset
//                    until cs has been seen high)
//   sample_data      {DATA_H, DATA_L} sample, loaded when sample_valid is high
//   sample_valid     one-cycle load strobe for sample_data
//   ctrl_reg         current value of register 0x01
//   wr_pulse         one-cycle pulse when an SPI write commits
//   wr_addr          address of the last committed write
//   frame_done       one-cycle pulse at the end of a complete 16-bit frame
module spi_register_target #(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [7:0]  DEVICE_ID   = 8'hE5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic [7:0]  ctrl_reg,
    output logic        wr_pulse,
    output logic [6:0]  wr_addr,
    output logic        frame_done
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        WAIT_CS_HIGH,
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    // Synchronizers; cleared to 0 so a cs held low across reset never looks
    // like an idle bus and the FSM stays in WAIT_CS_HIGH.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_q;
    logic                   sclk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_q      <= cs_sync[SYNC_STAGES-1];
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s, sclk_s, mosi_s;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;

    // Sample path: live DATA_L/DATA_H
    logic [7:0] data_l;
    logic [7:0] data_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_l <= '0;
            data_h <= '0;
        end else if (sample_valid) begin
            data_l <= sample_data[7:0];
            data_h <= sample_data[15:8];
        end
    end

    // Frame state
    state_t     state;
    logic [7:0] shift_in;
    logic [3:0] bit_cnt;
    logic       is_read;
    logic [6:0] addr;
    logic [7:0] rd_shift;
    logic [7:0] data_h_hold;
    logic [7:0] regs [NUM_REGS];

    // Values completed by the bit being sampled this cycle
    logic [6:0] cmd_addr;
    logic       cmd_read;
    logic [7:0] wr_data;
    logic [7:0] rd_lookup;
    logic       addr_rw;

    assign cmd_addr = {shift_in[5:0], mosi_s};
    assign cmd_read = shift_in[6];
    assign wr_data  = {shift_in[6:0], mosi_s};

    always_comb begin
        rd_lookup = '0;
        case (cmd_addr)
            7'h00:   rd_lookup = DEVICE_ID;
            7'h01:   rd_lookup = ctrl_reg;
            7'h02:   rd_lookup = data_l;
            7'h03:   rd_lookup = data_h_hold;
            default: begin
                if ({25'b0, cmd_addr} < NUM_REGS)
                    rd_lookup = regs[cmd_addr[AW-1:0]];
            end
        endcase
    end

    always_comb begin
        addr_rw = 1'b0;
        if (addr == 7'h01)
            addr_rw = 1'b1;
        else if (addr >= 7'h04 && {25'b0, addr} < NUM_REGS)
            addr_rw = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_CS_HIGH;
            shift_in    <= '0;
            bit_cnt     <= '0;
            is_read     <= 1'b0;
            addr        <= '0;
            rd_shift    <= '0;
            data_h_hold <= '0;
            ctrl_reg    <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_pulse    <= 1'b0;
            wr_addr     <= '0;
            frame_done  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            wr_pulse    <= 1'b0;
            frame_done  <= 1'b0;
            spi_miso_oe <= (state != WAIT_CS_HIGH) && !cs_s;

            case (state)
                WAIT_CS_HIGH: begin
                    spi_miso <= 1'b0;
                    if (cs_s)
                        state <= IDLE;
                end

                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        state   <= CMD;
                    end
                end

                CMD: begin
                    spi_miso <= 1'b0;
                    if (cs_rise) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        shift_in <= wr_data;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            is_read  <= cmd_read;
                            addr     <= cmd_addr;
                            rd_shift <= rd_lookup;
                            // Freeze DATA_H so a following 0x03 read matches
                            // the DATA_L byte being returned now.
                            if (cmd_read && cmd_addr == 7'h02)
                                data_h_hold <= data_h;
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (cs_rise) begin
                        spi_miso <= 1'b0;
                        state    <= IDLE;
                    end else if (sclk_rise) begin
                        shift_in <= wr_data;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            spi_miso <= 1'b0;
                            if (!is_read && addr_rw) begin
                                if (addr == 7'h01)
                                    ctrl_reg <= wr_data;
                                else
                                    regs[addr[AW-1:0]] <= wr_data;
                                wr_pulse <= 1'b1;
                                wr_addr  <= addr;
                            end
                            state <= DONE;
                        end
                    end else if (sclk_fall && is_read) begin
                        spi_miso <= rd_shift[7];
                        rd_shift <= {rd_shift[6:0], 1'b0};
                    end
                end

                DONE: begin
                    spi_miso <= 1'b0;
                    if (cs_rise) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= WAIT_CS_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_target.sv
// tb_spi_register_target
//   Scoreboard bench: expected read bytes and expected write commits are
//   queued when a frame is issued and popped when the DUT answers.
module tb_spi_register_target;

    localparam int HALF = 8;   // spi_clk half period in clk cycles

    logic        clk;
    logic        reset;
    logic        spi_cs;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic [7:0]  ctrl_reg;
    logic        wr_pulse;
    logic [6:0]  wr_addr;
    logic        frame_done;

    spi_register_target #(
        .NUM_REGS    (8),
        .DEVICE_ID   (8'hE5),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_cs       (spi_cs),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .ctrl_reg     (ctrl_reg),
        .wr_pulse     (wr_pulse),
        .wr_addr      (wr_addr),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;

    logic [7:0] exp_rd [$];
    logic [6:0] exp_wr [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Commit / frame-end monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done)
                fd_cnt++;
            if (wr_pulse) begin
                wr_cnt++;
                if (exp_wr.size() == 0)
                    check("wr_unexpected", 32'd1, 32'd0);
                else
                    check("wr_addr", {25'b0, wr_addr}, {25'b0, exp_wr.pop_front()});
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame of nbits bits (cs is raised early when nbits < 16)
    task automatic xfer(input logic [15:0] word, input int nbits, output logic [15:0] rx);
        rx = '0;
        spi_cs = 1'b0;
        wait_clks(HALF);
        check("miso_oe", {31'b0, spi_miso_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[15-i];
            wait_clks(HALF);
            rx[15-i] = spi_miso;
            spi_clk = 1'b1;
            wait_clks(HALF);
            spi_clk = 1'b0;
        end
        wait_clks(HALF);
        spi_cs = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp);
        logic [15:0] rx;
        int f0, w0;
        f0 = fd_cnt;
        w0 = wr_cnt;
        exp_rd.push_back(exp);
        xfer({1'b1, a, 8'h00}, 16, rx);
        check("rd_cmd_miso", {24'b0, rx[15:8]}, 32'd0);
        check("rd_data", {24'b0, rx[7:0]}, {24'b0, exp_rd.pop_front()});
        check("rd_frame_done", fd_cnt - f0, 32'd1);
        check("rd_no_write", wr_cnt - w0, 32'd0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d, input int commits);
        logic [15:0] rx;
        int f0, w0;
        f0 = fd_cnt;
        w0 = wr_cnt;
        if (commits != 0)
            exp_wr.push_back(a);
        xfer({1'b0, a, d}, 16, rx);
        check("wr_count", wr_cnt - w0, commits);
        check("wr_frame_done", fd_cnt - f0, 32'd1);
        check("wr_pending", exp_wr.size(), 32'd0);
    endtask

    task automatic load_sample(input logic [15:0] v);
        @(negedge clk);
        sample_data  = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] word;
        int f0, w0;

        reset        = 1'b1;
        spi_cs       = 1'b1;
        spi_clk      = 1'b0;
        spi_mosi     = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        wait_clks(5);
        check("rst_miso", {31'b0, spi_miso}, 32'd0);
        check("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
        check("rst_ctrl", {24'b0, ctrl_reg}, 32'd0);
        check("rst_wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("rst_wr_addr", {25'b0, wr_addr}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        wait_clks(6);
        check("idle_oe", {31'b0, spi_miso_oe}, 32'd0);

        // ID and CTRL
        rd(7'h00, 8'hE5);
        wr(7'h01, 8'h5A, 1);
        check("ctrl_after_wr", {24'b0, ctrl_reg}, 32'h5A);
        rd(7'h01, 8'h5A);

        // Coherent sample snapshot
        load_sample(16'h1234);
        rd(7'h02, 8'h34);
        load_sample(16'hABCD);
        rd(7'h03, 8'h12);
        rd(7'h02, 8'hCD);
        rd(7'h03, 8'hAB);

        // Aborted write after 12 bits
        f0 = fd_cnt;
        w0 = wr_cnt;
        xfer(16'h01FF, 12, rx);
        check("abort_ctrl", {24'b0, ctrl_reg}, 32'h5A);
        check("abort_no_write", wr_cnt - w0, 32'd0);
        check("abort_no_done", fd_cnt - f0, 32'd0);
        rd(7'h01, 8'h5A);

        // Illegal targets
        wr(7'h00, 8'h11, 0);
        wr(7'h7F, 8'h22, 0);
        wr(7'h02, 8'h33, 0);
        wr(7'h08, 8'h44, 0);
        rd(7'h00, 8'hE5);
        rd(7'h7F, 8'h00);
        rd(7'h08, 8'h00);
        rd(7'h02, 8'hCD);

        // Scratch registers at both ends of the range
        wr(7'h04, 8'hC3, 1);
        wr(7'h07, 8'h3C, 1);
        rd(7'h04, 8'hC3);
        rd(7'h07, 8'h3C);

        // Reset during bit 5 of a write, with cs held low
        f0 = fd_cnt;
        w0 = wr_cnt;
        word = 16'h01AA;
        spi_cs = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 16; i++) begin
            spi_mosi = word[15-i];
            wait_clks(HALF);
            if (i > 4) begin
                check("mid_rst_oe", {31'b0, spi_miso_oe}, 32'd0);
                check("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
            end
            spi_clk = 1'b1;
            if (i == 4) begin
                reset = 1'b1;
                wait_clks(2);
                reset = 1'b0;
                wait_clks(HALF - 2);
            end else begin
                wait_clks(HALF);
            end
            spi_clk = 1'b0;
        end
        wait_clks(HALF);
        spi_cs = 1'b1;
        wait_clks(HALF);
        check("mid_rst_no_write", wr_cnt - w0, 32'd0);
        check("mid_rst_no_done", fd_cnt - f0, 32'd0);
        check("mid_rst_ctrl", {24'b0, ctrl_reg}, 32'd0);
        rd(7'h00, 8'hE5);
        rd(7'h04, 8'h00);
        wr(7'h01, 8'h96, 1);
        rd(7'h01, 8'h96);

        check("scoreboard_empty", exp_rd.size() + exp_wr.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
